cp0_timer_intc: RTL
===================

# cp0_timer_intc

Parametrised count/compare timer and interrupt-pending controller for the CP0 register file. It generalises the single-compare timer and raw IP sampling to the following:
- a prescaled Count
- CMP_NUM independent sticky compare channels
- synchronised, stall-holding hardware interrupt sampling
- a registered, prioritised interrupt request toward the exception stage

CP0 forwards COUNT/COMPARE writes here and takes Count, Compare, Cause.IP and the timer interrupt from this block.

## Interface
Parameters:
- HW_INT_NUM, 6: hardware interrupt lines, mapped to IP[2+i]; range 1..6.
- CMP_NUM, 1: compare channels; range 1..4.
- COUNT_DIV, 1: cycles per Count increment; range 1..16.
- SYNC_STAGES, 2: synchroniser depth when CP0_INT_SYNC_EN is defined; range 2..3.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we_i  in  1  CP0 write strobe.
- waddr_i  in  5  CP0 register number; 9 = COUNT, 11 = COMPARE.
- sel_i  in  3  selects the compare channel for waddr_i = 11; values ≥ CMP_NUM are ignored.
- wdata_i  in  32  write data.
- hw_int_i  in  HW_INT_NUM  asynchronous level interrupts.
- stall_i  in  1  bus stall; freezes IP sampling.
- status_ie_i  in  1  Status.IE.
- status_exl_i  in  1  Status.EXL.
- status_im_i  in  8  Status.IM.
- ip_sw_i  in  2  Cause.IP[1:0] from CP0.
- count_o  out  32  Count.
- compare_o  out  32*CMP_NUM  compare channels, with channel k at [32k+31:32k].
- cause_ip_o  out  8  Cause.IP[7:0].
- timer_int_o  out  1  OR of all channel pending bits.
- int_req_o  out  1  registered interrupt request.
- int_vec_o  out  3  index of the highest-numbered pending and enabled IP bit.

## Operation
Prescaler and Count:
- div_cnt counts 0..COUNT_DIV-1. tick = (div_cnt == COUNT_DIV-1).
- Count increments by 1 on tick and wraps from 0xFFFF_FFFF to 0.
- A COUNT write loads wdata_i, clears div_cnt, and overrides the increment in that cycle.

Compare channel k:
- A COMPARE write with sel_i == k loads compare[k] and clears pend[k].
- Otherwise pend[k] is set when count_q == compare[k] and compare[k] != 0. A zero compare disarms the channel.
- pend[k] is sticky.
- If a write clear and a match occur in the same cycle, the clear wins.
- timer_int_o is the OR of all pend bits.

IP sampling:
- hw_s is hw_int_i after the synchroniser.
- Each cycle with stall_i = 0: ip_hw[i] ← hw_s[i], except ip_hw[5] ← hw_s[5] | timer_int. For HW_INT_NUM < 6, unused lines read 0.
- With stall_i = 1, ip_hw holds its value. It is never zeroed.
- cause_ip_o = {ip_hw[5:0], ip_sw_i}.

Interrupt request:
- req = status_ie_i & ~status_exl_i & |(cause_ip_o & status_im_i), registered into int_req_o.
- int_vec_o registers the priority encode of (cause_ip_o & status_im_i); 7 is the highest priority. It is 0 when req = 0.

## Timing
- Reset values: Count, every compare, every pend, div_cnt, all synchroniser flops, cause_ip_o[7:2], int_req_o and int_vec_o are 0. cause_ip_o[1:0] follows ip_sw_i.
- A COUNT or COMPARE write is visible on the outputs the cycle after we_i.
- Compare match: pend, and therefore timer_int_o, rises 1 cycle after count_q equals compare. IP[7] rises 1 cycle later, and int_req_o 1 cycle after that.
- With COUNT_DIV > 1, count_q equals compare for COUNT_DIV cycles. pend is set once and stays set.
- hw_int_i to cause_ip_o: SYNC_STAGES+1 cycles with CP0_INT_SYNC_EN defined, 1 cycle without, plus any stall cycles.
- Status change to int_req_o: 1 cycle.
- Asserting rst_n low mid-operation clears all state immediately, without waiting for clk. The first tick after release occurs COUNT_DIV cycles later.

## Configuration
- CP0_INT_SYNC_EN defined: each hw_int_i bit passes through a SYNC_STAGES-flop synchroniser before the IP register.
- CP0_INT_SYNC_EN undefined: hw_int_i is sampled directly into the IP register. This is for sources already synchronous to clk.

## Test plan
- Reset and count: COUNT_DIV=2, release rst_n, then no writes → count_o = 5 at cycle 10 after release; all other outputs 0.
- Match and clear:
  - Write COMPARE sel 0 = 0x20 → timer_int_o = 1 one cycle after count_o = 0x20; it stays 1 while Count passes 0x21.
  - Rewrite COMPARE sel 0 = 0x100 → timer_int_o = 0 the next cycle.
- Simultaneous clear and match: CMP_NUM=2. Write COMPARE sel 1 in the exact cycle count_q == compare[1] → pend[1] stays 0. Channel 0 is unaffected.
- Wrap: write COUNT = 0xFFFF_FFFE and COMPARE = 1 → Count reads FFFF_FFFF, 0, 1; timer_int_o asserts after Count reads 1.
- Stall hold: drive hw_int_i[2] = 1 and wait until IP[4] = 1. Assert stall_i and drop hw_int_i → IP[4] stays 1 until stall_i deasserts, then clears after the sync latency.
- Priority and gating: IP[3] and IP[7] pending, IM = 0xFF, IE = 1, EXL = 0 → int_req_o = 1 and int_vec_o = 7. Set EXL = 1 → int_req_o = 0 the next cycle.

Source files
------------

// File: rtl/cp0_timer_intc.sv
// rtl/cp0_timer_intc.sv - CP0 Count/Compare timer and prioritised interrupt-pending controller
//
// Purpose: prescaled Count, CMP_NUM sticky compare channels, stall-holding
// hardware interrupt sampling into Cause.IP, and a registered interrupt
// request with a priority-encoded vector toward the exception stage.
//
// Optional feature macro: CP0_INT_SYNC_EN
//   defined   - hw_int_i passes through a SYNC_STAGES-flop synchroniser
//   undefined - hw_int_i is sampled directly (sources synchronous to clk)
//
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   we_i, waddr_i,     CP0 write strobe, register number (9 COUNT, 11 COMPARE),
//   sel_i, wdata_i     compare channel select, write data
//   hw_int_i           asynchronous level interrupts, mapped to IP[2+i]
//   stall_i            freezes IP sampling
//   status_ie_i,       Status.IE, Status.EXL, Status.IM
//   status_exl_i,
//   status_im_i
//   ip_sw_i            software interrupt bits Cause.IP[1:0]
//   count_o            Count
//   compare_o          compare channels, channel k at [32k+31:32k]
//   cause_ip_o         Cause.IP[7:0]
//   timer_int_o        OR of all compare pending bits
//   int_req_o          registered interrupt request
//   int_vec_o          registered index of highest pending and enabled IP bit

module cp0_timer_intc #(
   parameter int HW_INT_NUM  = 6,
   parameter int CMP_NUM     = 1,
   parameter int COUNT_DIV   = 1,
   parameter int SYNC_STAGES = 2
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we_i,
   input  logic [4:0]              waddr_i,
   input  logic [2:0]              sel_i,
   input  logic [31:0]             wdata_i,
   input  logic [HW_INT_NUM-1:0]   hw_int_i,
   input  logic                    stall_i,
   input  logic                    status_ie_i,
   input  logic                    status_exl_i,
   input  logic [7:0]              status_im_i,
   input  logic [1:0]              ip_sw_i,
   output logic [31:0]             count_o,
   output logic [32*CMP_NUM-1:0]   compare_o,
   output logic [7:0]              cause_ip_o,
   output logic                    timer_int_o,
   output logic                    int_req_o,
   output logic [2:0]              int_vec_o
);

   localparam int              DIV_W    = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(COUNT_DIV - 1);

   logic [DIV_W-1:0]             div_cnt_q, div_cnt_d;
   logic [31:0]                  count_q, count_d;
   logic [CMP_NUM-1:0][31:0]     compare_q, compare_d;
   logic [CMP_NUM-1:0]           pend_q, pend_d;
   logic [5:0]                   ip_hw_q, ip_hw_d;
   logic                         int_req_q, int_req_d;
   logic [2:0]                   int_vec_q, int_vec_d;

   logic                         tick;
   logic                         wr_count;
   logic                         wr_cmp;
   logic                         timer_int;
   logic [HW_INT_NUM-1:0]        hw_s;
   logic [5:0]                   hw_ext;
   logic [7:0]                   masked;
   logic [2:0]                   vec;
   logic                         req;

   assign tick     = (div_cnt_q == DIV_LAST);
   assign wr_count = we_i && (waddr_i == 5'd9);
   assign wr_cmp   = we_i && (waddr_i == 5'd11);

   // A COUNT write restarts the prescaler so the next tick is a full period away.
   always_comb begin
      div_cnt_d = div_cnt_q + 1'b1;
      count_d   = count_q;
      if (tick) begin
         div_cnt_d = '0;
         count_d   = count_q + 32'd1;
      end
      if (wr_count) begin
         div_cnt_d = '0;
         count_d   = wdata_i;
      end
   end

   // The write clear is tested first so it beats a same-cycle match.
   always_comb begin
      compare_d = compare_q;
      pend_d    = pend_q;
      for (int k = 0; k < CMP_NUM; k++) begin
         if (wr_cmp && (sel_i == 3'(k))) begin
            compare_d[k] = wdata_i;
            pend_d[k]    = 1'b0;
         end else if ((count_q == compare_q[k]) && (compare_q[k] != 32'd0)) begin
            pend_d[k] = 1'b1;
         end
      end
   end

   assign timer_int = |pend_q;

`ifdef CP0_INT_SYNC_EN
   logic [SYNC_STAGES-1:0][HW_INT_NUM-1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], hw_int_i};
      end
   end

   assign hw_s = sync_q[SYNC_STAGES-1];
`else
   assign hw_s = hw_int_i;
`endif

   // Lines beyond HW_INT_NUM read as zero; the timer shares IP[7] with line 5.
   always_comb begin
      hw_ext                 = '0;
      hw_ext[HW_INT_NUM-1:0] = hw_s;
      ip_hw_d                = stall_i ? ip_hw_q : {hw_ext[5] | timer_int, hw_ext[4:0]};
   end

   assign cause_ip_o = {ip_hw_q, ip_sw_i};
   assign masked     = cause_ip_o & status_im_i;
   assign req        = status_ie_i & ~status_exl_i & (|masked);

   // Ascending scan so the highest-numbered set bit wins.
   always_comb begin
      vec = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (masked[i]) begin
            vec = 3'(i);
         end
      end
      int_req_d = req;
      int_vec_d = req ? vec : 3'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt_q <= '0;
         count_q   <= '0;
         compare_q <= '0;
         pend_q    <= '0;
         ip_hw_q   <= '0;
         int_req_q <= 1'b0;
         int_vec_q <= 3'd0;
      end else begin
         div_cnt_q <= div_cnt_d;
         count_q   <= count_d;
         compare_q <= compare_d;
         pend_q    <= pend_d;
         ip_hw_q   <= ip_hw_d;
         int_req_q <= int_req_d;
         int_vec_q <= int_vec_d;
      end
   end

   assign count_o     = count_q;
   assign compare_o   = compare_q;
   assign timer_int_o = timer_int;
   assign int_req_o   = int_req_q;
   assign int_vec_o   = int_vec_q;

endmodule
